// File: rtl/lut_loader.sv
// rtl/lut_loader.sv - burst loader that fills a DEPTH x DATA_W lookup table and reads it back
module lut_loader #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   wr_count,
    output logic [DATA_W-1:0] checksum,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] COUNT_ONE = 1;

    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W:0]   burst_len;
    logic              transfer;
    logic              last_word;

    assign transfer  = (state == LOAD) && in_valid;
    assign last_word = (wr_count == burst_len - COUNT_ONE);

    // Handshake and status come straight from the state register.
    assign in_ready = (state == LOAD);
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (len == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (transfer && last_word) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_addr   <= '0;
            burst_len <= '0;
            wr_count  <= '0;
            checksum  <= '0;
        end else if (state == IDLE && start) begin
            wr_addr   <= base_addr;
            burst_len <= len;
            wr_count  <= '0;
            checksum  <= '0;
        end else if (transfer) begin
            wr_addr  <= wr_addr + 1'b1;
            wr_count <= wr_count + COUNT_ONE;
            checksum <= checksum + in_data;
        end
    end

    // Table is never cleared; reset only suppresses a write in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst && transfer) begin
            mem[wr_addr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule
